multicycle_control_fsm: RTL and testbench

Multi-cycle sequencer for the LEGv8 datapath, replacing single-cycle decode with a Moore FSM. Steps each instruction through fetch/decode/execute/memory/writeback using one shared memory port with a ready handshake and a timeout. Drives the same control set as the single-cycle decoder (Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp), plus PC/IR write enables.

---
 rtl/multicycle_control_fsm.sv | 149 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: LEGv8 multi-cycle Moore sequencer; define ILLEGAL_TRAP_EN to halt on illegal opcodes
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] instruction_part,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        instr_done,
  output logic        mem_err,
  output logic        illegal,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_LD  = 4'd8,
    S_BRANCH = 4'd9
`ifdef ILLEGAL_TRAP_EN
    , S_HALT = 4'd10
`endif
  } state_t;
`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_ILL = S_HALT;
`else
  localparam state_t S_ILL = S_FETCH;
`endif
  localparam logic [TO_W-1:0] LIM = TO_W'(MEM_TIMEOUT);
  state_t r_state, w_next;
  logic [TO_W-1:0] r_cnt;
  logic w_is_r, w_is_ld, w_is_st, w_is_cbz, w_wait, w_to;
  assign w_is_r   = (instruction_part & 11'b10011110111) == 11'b10001010000;
  assign w_is_ld  = instruction_part == 11'b11111000010;
  assign w_is_st  = instruction_part == 11'b11111000000;
  assign w_is_cbz = instruction_part[10:3] == 8'b10110100;
  assign w_wait   = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign w_to     = w_wait && !mem_ready && (MEM_TIMEOUT != 0) && (r_cnt == LIM);
  assign state    = reset_n ? r_state : 4'd0;
  // state register and memory-wait counter, cleared on every state entry and on a timeout retry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || w_to) ? '0 : r_cnt + TO_W'(w_wait && !mem_ready);
    end
  end
  // next state and Moore control outputs, all forced low while reset is held
  always_comb begin
    w_next     = r_state;
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    ALUOp      = 2'b00;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    instr_done = 1'b0;
    mem_err    = 1'b0;
    illegal    = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_RESET: w_next = S_FETCH;
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          mem_err = w_to;
          w_next  = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          Reg2Loc = w_is_cbz || w_is_st;
          illegal = !(w_is_r || w_is_ld || w_is_st || w_is_cbz);
          w_next  = w_is_r ? S_EXEC_R : (w_is_ld || w_is_st) ? S_ADDR : w_is_cbz ? S_BRANCH : S_ILL;
        end
        S_EXEC_R: begin
          ALUOp  = 2'b10;
          w_next = S_WB_R;
        end
        S_WB_R: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_ADDR: begin
          ALUSrc = 1'b1;
          w_next = w_is_ld ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          ALUSrc  = 1'b1;
          mem_err = w_to;
          w_next  = mem_ready ? S_WB_LD : w_to ? S_FETCH : S_MEM_RD;
        end
        S_WB_LD: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEM_WR: begin
          MemWrite   = 1'b1;
          Reg2Loc    = 1'b1;
          ALUSrc     = 1'b1;
          instr_done = mem_ready;
          mem_err    = w_to;
          w_next     = (mem_ready || w_to) ? S_FETCH : S_MEM_WR;
        end
        S_BRANCH: begin
          Reg2Loc    = 1'b1;
          ALUOp      = 2'b01;
          Branch     = 1'b1;
          PCWrite    = zero;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: begin
          illegal = 1'b1;
          w_next  = S_HALT;
        end
`endif
        default: w_next = S_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed and randomized check of the multi-cycle sequencer against an instruction-step model
module tb_multicycle_control_fsm;
  localparam int MT = 15;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;
  // {Reg2Loc,ALUSrc,MemtoReg,RegWrite, MemRead,MemWrite,Branch, ALUOp, IRWrite,PCWrite,instr_done, mem_err,illegal}
  localparam logic [13:0] O_NONE   = 14'b0000_000_00_000_00;
  localparam logic [13:0] O_FRDY   = 14'b0000_100_00_110_00;
  localparam logic [13:0] O_FWAIT  = 14'b0000_100_00_000_00;
  localparam logic [13:0] O_DEC_RS = 14'b1000_000_00_000_00;
  localparam logic [13:0] O_EXEC   = 14'b0000_000_10_000_00;
  localparam logic [13:0] O_WBR    = 14'b0001_000_00_001_00;
  localparam logic [13:0] O_ADDR   = 14'b0100_000_00_000_00;
  localparam logic [13:0] O_MRD    = 14'b0100_100_00_000_00;
  localparam logic [13:0] O_WBLD   = 14'b0011_000_00_001_00;
  localparam logic [13:0] O_BR1    = 14'b1000_001_01_011_00;
  localparam logic [13:0] O_BR0    = 14'b1000_001_01_001_00;
  localparam logic [13:0] O_MWR    = 14'b1100_010_00_000_00;
  localparam logic [13:0] O_MWR_TO = 14'b1100_010_00_000_10;
  localparam logic [13:0] O_ILL    = 14'b0000_000_00_000_01;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic [10:0] instruction_part = '0;
  logic Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0] ALUOp;
  logic IRWrite, PCWrite, instr_done, mem_err, illegal;
  logic [3:0] state;
  logic [13:0] outs;
  int checks = 0;
  int failures = 0;
  int step_no = 0;
  bit running = 1'b1;
  int m_st = 0;
  int m_cnt = 0;
  int m_q[$];
  multicycle_control_fsm #(.MEM_TIMEOUT(MT), .TO_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .instruction_part(instruction_part), .zero(zero), .mem_ready(mem_ready),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .instr_done(instr_done), .mem_err(mem_err), .illegal(illegal), .state(state)
  );
  assign outs = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, IRWrite, PCWrite, instr_done, mem_err, illegal};
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
  // instruction class: 0 illegal, 1 R-type, 2 LDUR, 3 STUR, 4 CBZ
  function automatic int cls(input logic [10:0] op);
    if (op[10] && op[7:4] == 4'b0101 && op[2:0] == 3'b000) return 1;
    if (op == OP_LDUR) return 2;
    if (op == OP_STUR) return 3;
    if (op[10:3] == 8'b10110100) return 4;
    return 0;
  endfunction
  function automatic logic [13:0] exp_outs();
    logic [13:0] o;
    logic to;
    int c;
    o = '0;
    c = cls(instruction_part);
    if (!reset_n) return '0;
    to = (MT != 0) && (m_cnt == MT) && !mem_ready;
    case (m_st)
      1: begin o[9] = 1'b1; o[4] = mem_ready; o[3] = mem_ready; o[1] = to; end
      2: begin o[13] = (c == 3 || c == 4); o[0] = (c == 0); end
      3: o[6:5] = 2'b10;
      4: o[12] = 1'b1;
      5: begin o[12] = 1'b1; o[9] = 1'b1; o[1] = to; end
      6: begin o[13] = 1'b1; o[12] = 1'b1; o[8] = 1'b1; o[2] = mem_ready; o[1] = to; end
      7: begin o[10] = 1'b1; o[2] = 1'b1; end
      8: begin o[11] = 1'b1; o[10] = 1'b1; o[2] = 1'b1; end
      9: begin o[13] = 1'b1; o[7] = 1'b1; o[6:5] = 2'b01; o[3] = zero; o[2] = 1'b1; end
      10: o[0] = 1'b1;
      default: ;
    endcase
    return o;
  endfunction
  task automatic next_step();
    m_st = (m_q.size() > 0) ? m_q.pop_front() : 1;
    m_cnt = 0;
  endtask
  // model: each instruction is a list of steps; steps 1/5/6 wait for memory
  task automatic model_step();
    logic to;
    if (!reset_n) begin
      m_st = 0;
      m_q.delete();
      m_cnt = 0;
      return;
    end
    to = (MT != 0) && (m_cnt == MT) && !mem_ready;
    if (m_st == 0) m_st = 1;
    else if (m_st == 10) m_st = 10;
    else if (m_st == 1 || m_st == 5 || m_st == 6) begin
      if (mem_ready) begin
        if (m_st == 1) begin
          m_q.delete();
          m_q.push_back(2);
          case (cls(instruction_part))
            1: begin m_q.push_back(3); m_q.push_back(7); end
            2: begin m_q.push_back(4); m_q.push_back(5); m_q.push_back(8); end
            3: begin m_q.push_back(4); m_q.push_back(6); end
            4: m_q.push_back(9);
            default: begin
`ifdef ILLEGAL_TRAP_EN
              m_q.push_back(10);
`endif
            end
          endcase
        end
        next_step();
      end else if (to) begin
        m_st = 1;
        m_q.delete();
        m_cnt = 0;
      end else m_cnt++;
    end else next_step();
  endtask
  // model comparison on every cycle, away from the clock edge
  always @(negedge clk) begin
    #2;
    if (running) begin
      checks++;
      if (outs !== exp_outs() || state !== (reset_n ? m_st[3:0] : 4'd0)) begin
        failures++;
        $display("FAIL model_cmp t=%0t state got=%0d exp=%0d outs got=%b exp=%b", $time, state, reset_n ? m_st : 0, outs, exp_outs());
      end
    end
  end
  task automatic apply(input logic rn, input logic [10:0] op, input logic rdy, input logic z);
    reset_n = rn;
    instruction_part = op;
    mem_ready = rdy;
    zero = z;
    #3;
  endtask
  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic dstep(input logic rn, input logic [10:0] op, input logic rdy, input logic z, input logic [3:0] est, input logic [13:0] eo);
    apply(rn, op, rdy, z);
    step_no++;
    checks++;
    if (state !== est || outs !== eo) begin
      failures++;
      $display("FAIL directed_step%0d state got=%0d exp=%0d outs got=%b exp=%b", step_no, state, est, outs, eo);
    end
    advance();
  endtask
  function automatic logic [10:0] pick_op();
    logic [10:0] r;
    r = 11'($urandom);
    case ($urandom_range(0, 7))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_ORR;
      3: return OP_LDUR;
      4: return OP_STUR;
      5: return {8'b10110100, r[2:0]};
      6: return r;
      default: return OP_AND;
    endcase
  endfunction
  initial begin
    int rst_hold;
    bit dead;
    logic [10:0] op;
    rst_hold = 0;
    dead = 1'b0;
    @(negedge clk);
    repeat (3) dstep(1'b0, OP_ADD, 1'b0, 1'b0, 4'd0, O_NONE);
    dstep(1'b1, OP_ADD, 1'b1, 1'b0, 4'd0, O_NONE);
    dstep(1'b1, OP_ADD, 1'b1, 1'b0, 4'd1, O_FRDY);
    dstep(1'b1, OP_ADD, 1'b1, 1'b0, 4'd2, O_NONE);
    dstep(1'b1, OP_ADD, 1'b1, 1'b0, 4'd3, O_EXEC);
    dstep(1'b1, OP_ADD, 1'b1, 1'b0, 4'd7, O_WBR);
    dstep(1'b1, OP_LDUR, 1'b1, 1'b0, 4'd1, O_FRDY);
    dstep(1'b1, OP_LDUR, 1'b1, 1'b0, 4'd2, O_NONE);
    dstep(1'b1, OP_LDUR, 1'b1, 1'b0, 4'd4, O_ADDR);
    dstep(1'b1, OP_LDUR, 1'b0, 1'b0, 4'd5, O_MRD);
    dstep(1'b1, OP_LDUR, 1'b0, 1'b0, 4'd5, O_MRD);
    dstep(1'b1, OP_LDUR, 1'b1, 1'b0, 4'd5, O_MRD);
    dstep(1'b1, OP_LDUR, 1'b1, 1'b0, 4'd8, O_WBLD);
    dstep(1'b1, OP_CBZ, 1'b1, 1'b1, 4'd1, O_FRDY);
    dstep(1'b1, OP_CBZ, 1'b1, 1'b1, 4'd2, O_DEC_RS);
    dstep(1'b1, OP_CBZ, 1'b1, 1'b1, 4'd9, O_BR1);
    dstep(1'b1, OP_CBZ, 1'b1, 1'b0, 4'd1, O_FRDY);
    dstep(1'b1, OP_CBZ, 1'b1, 1'b0, 4'd2, O_DEC_RS);
    dstep(1'b1, OP_CBZ, 1'b1, 1'b0, 4'd9, O_BR0);
    dstep(1'b1, OP_STUR, 1'b1, 1'b0, 4'd1, O_FRDY);
    dstep(1'b1, OP_STUR, 1'b1, 1'b0, 4'd2, O_DEC_RS);
    dstep(1'b1, OP_STUR, 1'b1, 1'b0, 4'd4, O_ADDR);
    repeat (15) dstep(1'b1, OP_STUR, 1'b0, 1'b0, 4'd6, O_MWR);
    dstep(1'b1, OP_STUR, 1'b0, 1'b0, 4'd6, O_MWR_TO);
    dstep(1'b1, OP_BAD, 1'b1, 1'b0, 4'd1, O_FRDY);
    dstep(1'b1, OP_BAD, 1'b1, 1'b0, 4'd2, O_ILL);
`ifdef ILLEGAL_TRAP_EN
    repeat (3) dstep(1'b1, OP_BAD, 1'b0, 1'b0, 4'd10, O_ILL);
    dstep(1'b0, OP_BAD, 1'b0, 1'b0, 4'd0, O_NONE);
    dstep(1'b1, OP_BAD, 1'b0, 1'b0, 4'd0, O_NONE);
`endif
    dstep(1'b1, OP_BAD, 1'b0, 1'b0, 4'd1, O_FWAIT);
    op = OP_ADD;
    for (int i = 0; i < 3000; i++) begin
      if (rst_hold == 0 && $urandom_range(0, 299) == 0) rst_hold = $urandom_range(1, 3);
      if (m_st == 1) op = pick_op();
      if (m_cnt == 0) dead = ($urandom_range(0, 9) == 0);
      apply(rst_hold == 0, op, dead ? 1'b0 : ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)));
      if (rst_hold > 0) rst_hold--;
      advance();
    end
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
